io_dev_scheduler: RTL and testbench
===================================

Name: io_dev_scheduler

Overview:
- Sits between the I/O electronic unit's device-side handshakes and the physical peripherals.
- Input side: shares the single 5-bit input port between two sources, tape reader (src 0) and panel keyboard (src 1), using a per-character grant lock.
- Output side: buffers output characters in a small FIFO, then fans each one out to the enabled sinks, printer (sink 0) and punch (sink 1). The output unit is never stalled by a slow printer while buffer space remains.

Parameters:
DEPTH, 4, output FIFO entries; power of two, 2..16
TIMEOUT_CYCLES, 1000000, sink watchdog limit; used only with IO_DEV_TIMEOUT_EN

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
input_rdy_from_io  in  1  unit ready for an input character
input_val_to_io  out  1  valid to unit, muxed from the granted source
input_data_to_io  out  5  data to unit, muxed from the granted source
src_rdy_to_dev  out  2  per-source ready
src_val_from_dev  in  2  per-source valid
src_data0_from_dev  in  5  tape reader data
src_data1_from_dev  in  5  keyboard data
input_src_sel_from_pnl  in  1  level, 0 = tape, 1 = keyboard
output_rdy_from_io  in  1  unit presents an output character
output_data_from_io  in  5  output character from unit
output_ack_to_io  out  1  ack to unit
snk_rdy_to_dev  out  2  per-sink ready
snk_ack_from_dev  in  2  per-sink ack
snk_data_to_dev  out  5  FIFO head, shared by both sinks
snk_en_from_pnl  in  2  level, sink enables
flush_from_pnl  in  1  pulse, clears the output path
output_busy_to_pnl  out  1  FIFO not empty or sink FSM not idle
timeout_to_pnl  out  1  sticky watchdog flag

Behaviour:
- Handshakes: all are 4-phase (rdy up, val/ack up, rdy down, val/ack down).
- Reset: all outputs 0; FSMs idle; FIFO empty; grant 0; mask 0; timeout flag 0.
- Input FSM, I_IDLE: on input_rdy_from_io=1, latch grant = input_src_sel_from_pnl and go to I_ARM.
- Input FSM, I_ARM:
  - src_rdy_to_dev[grant]=1; the other source's rdy stays 0.
  - input_val_to_io = src_val_from_dev[grant]; input_data_to_io = granted source's data. Both are combinational, zero latency.
  - If granted val=1, go to I_HOLD.
  - Else if input_rdy_from_io=0 (unit aborted), go to I_IDLE.
- Input FSM, I_HOLD: src_rdy=0; val and data keep forwarding; when granted val=0, go to I_IDLE.
- Grant is frozen from I_ARM until return to I_IDLE; panel select changes mid-character are ignored.
- In I_IDLE, input_val_to_io=0 and input_data_to_io=0.
- Unit side, O_IDLE: if output_rdy_from_io=1 and count<DEPTH, push output_data_from_io (single push) and go to O_ACK.
- Unit side, O_ACK: output_ack_to_io=1; when output_rdy_from_io=0, go to O_IDLE.
- Full FIFO: ack is withheld until count<DEPTH. Count is evaluated on the registered value, so a pop in the same cycle does not allow a push.
- FIFO: count is clog2(DEPTH+1) bits; pointers wrap modulo DEPTH; a simultaneous push and pop leaves count unchanged.
- Sink FSM, S_IDLE: if FIFO not empty, latch mask = snk_en_from_pnl.
  - mask=0: pop and discard in 1 cycle, stay in S_IDLE.
  - Else go to S_RDY.
- Sink FSM, S_RDY:
  - snk_rdy_to_dev = mask & ~got; got |= snk_ack_from_dev & mask.
  - When got==mask, go to S_REL.
- Sink FSM, S_REL: rdy=0; when (snk_ack_from_dev & mask)==0, pop, clear got, go to S_IDLE.
- snk_data_to_dev is held stable for the whole S_RDY/S_REL span.
- Flush (any state): FIFO cleared; sink FSM to S_IDLE with rdy dropped and got cleared. The unit-side FSM and the input side are unaffected. If a push and a flush occur in the same cycle, flush wins (the character is dropped).
- output_busy_to_pnl = (count!=0) || sink FSM != S_IDLE; registered-state derived.

Optional Feature:
- Macro IO_DEV_TIMEOUT_EN defined:
  - A counter runs while in S_RDY or S_REL and clears on entry to S_IDLE.
  - When it reaches TIMEOUT_CYCLES: set timeout_to_pnl (sticky until reset), drop rdy, pop the head, go to S_IDLE.
- Macro undefined: no counter; sinks are waited on indefinitely; timeout_to_pnl is tied 0.

Decomposition:
- Package io_dev_pkg: input, unit-side and sink state encodings; SRC_TAPE=0, SRC_KBD=1; SNK_PRN=0, SNK_PUNCH=1; CHAR_W=5.
- One sub-module, io_dev_fifo: DEPTH x 5 storage, push/pop/flush, count/empty/full, asynchronous reset.

Test Plan:
1. Sel=0, unit rdy=1; tape val=1 data=5'b10011 -> src_rdy_to_dev=2'b01; input_data_to_io=5'b10011 while val; back to I_IDLE after val drops; keyboard rdy never asserted.
2. Toggle sel 0->1 while in I_HOLD -> grant stays tape through val drop; the next character grants keyboard.
3. Sinks held silent; push DEPTH+1 characters -> first 4 acked; 5th ack withheld until first sink pop; FIFO order preserved.
4. mask=2'b11, punch acks 3 cycles after printer -> each rdy drops individually on its own ack; pop only after both acks low; mask=2'b00 -> character discarded in 1 cycle.
5. Flush with 3 entries and sink in S_RDY -> snk_rdy=0 next cycle; count=0; output_busy_to_pnl=0 once acks low.
6. IO_DEV_TIMEOUT_EN with TIMEOUT_CYCLES=16, sink never acks -> timeout_to_pnl=1 after 16 cycles in S_RDY; head popped; flag stays set until resetn.

Source files
------------

// File: rtl/io_dev_pkg.sv
// io_dev_pkg: shared constants for the I/O device scheduler.
// State encodings for the input, unit-side and sink FSMs plus source/sink indices.
package io_dev_pkg;

  localparam int CHAR_W = 5;

  localparam int SRC_TAPE  = 0;
  localparam int SRC_KBD   = 1;
  localparam int SNK_PRN   = 0;
  localparam int SNK_PUNCH = 1;

  // Input-side FSM
  localparam logic [1:0] I_IDLE = 2'd0;
  localparam logic [1:0] I_ARM  = 2'd1;
  localparam logic [1:0] I_HOLD = 2'd2;

  // Unit-side (output acceptance) FSM
  localparam logic [0:0] O_IDLE = 1'b0;
  localparam logic [0:0] O_ACK  = 1'b1;

  // Sink fan-out FSM
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RDY  = 2'd1;
  localparam logic [1:0] S_REL  = 2'd2;

endpackage

// File: rtl/io_dev_fifo.sv
// io_dev_fifo: DEPTH x W character buffer with push/pop/flush.
// Push into a full FIFO and pop from an empty one are ignored; flush beats both.
module io_dev_fifo
  import io_dev_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = CHAR_W
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty = (count_r == CW'(0));
  assign full  = (count_r == CW'(DEPTH));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify requests against current occupancy; flush suppresses both.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    if (!flush) begin
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
    end else begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of two).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else if (flush) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CW'(0);
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Character storage, cleared on reset so the head never shows stale data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/io_dev_scheduler.sv
// io_dev_scheduler: arbitrates the unit's input port between tape reader and keyboard,
// and buffers/fans out output characters to printer and punch.
// Optional sink watchdog: define IO_DEV_TIMEOUT_EN.
module io_dev_scheduler
  import io_dev_pkg::*;
#(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              input_rdy_from_io,
  output logic              input_val_to_io,
  output logic [CHAR_W-1:0] input_data_to_io,
  output logic [1:0]        src_rdy_to_dev,
  input  logic [1:0]        src_val_from_dev,
  input  logic [CHAR_W-1:0] src_data0_from_dev,
  input  logic [CHAR_W-1:0] src_data1_from_dev,
  input  logic              input_src_sel_from_pnl,
  input  logic              output_rdy_from_io,
  input  logic [CHAR_W-1:0] output_data_from_io,
  output logic              output_ack_to_io,
  output logic [1:0]        snk_rdy_to_dev,
  input  logic [1:0]        snk_ack_from_dev,
  output logic [CHAR_W-1:0] snk_data_to_dev,
  input  logic [1:0]        snk_en_from_pnl,
  input  logic              flush_from_pnl,
  output logic              output_busy_to_pnl,
  output logic              timeout_to_pnl
);

  localparam int CW = $clog2(DEPTH + 1);

  // ---------------- input side ----------------
  logic [1:0] i_state_r;
  logic [1:0] i_state_nxt_s;
  logic       grant_r;
  logic       grant_nxt_s;
  logic       sel_val_s;

  assign sel_val_s = grant_r ? src_val_from_dev[SRC_KBD] : src_val_from_dev[SRC_TAPE];

  // Input FSM next state; grant only changes when leaving I_IDLE.
  always_comb begin
    i_state_nxt_s = i_state_r;
    grant_nxt_s   = grant_r;
    case (i_state_r)
      I_IDLE: begin
        if (input_rdy_from_io) begin
          grant_nxt_s   = input_src_sel_from_pnl;
          i_state_nxt_s = I_ARM;
        end else begin
          i_state_nxt_s = I_IDLE;
        end
      end
      I_ARM: begin
        if (sel_val_s)               i_state_nxt_s = I_HOLD;
        else if (!input_rdy_from_io) i_state_nxt_s = I_IDLE;
        else                         i_state_nxt_s = I_ARM;
      end
      I_HOLD: begin
        if (!sel_val_s) i_state_nxt_s = I_IDLE;
        else            i_state_nxt_s = I_HOLD;
      end
      default: i_state_nxt_s = I_IDLE;
    endcase
  end

  // Input FSM state and grant registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_state_r <= I_IDLE;
      grant_r   <= 1'b0;
    end else begin
      i_state_r <= i_state_nxt_s;
      grant_r   <= grant_nxt_s;
    end
  end

  // Zero-latency forwarding of the granted source toward the unit.
  always_comb begin
    src_rdy_to_dev   = 2'b00;
    input_val_to_io  = 1'b0;
    input_data_to_io = {CHAR_W{1'b0}};
    case (i_state_r)
      I_ARM: begin
        src_rdy_to_dev   = grant_r ? 2'b10 : 2'b01;
        input_val_to_io  = sel_val_s;
        input_data_to_io = grant_r ? src_data1_from_dev : src_data0_from_dev;
      end
      I_HOLD: begin
        input_val_to_io  = sel_val_s;
        input_data_to_io = grant_r ? src_data1_from_dev : src_data0_from_dev;
      end
      default: begin
        src_rdy_to_dev   = 2'b00;
        input_val_to_io  = 1'b0;
        input_data_to_io = {CHAR_W{1'b0}};
      end
    endcase
  end

  // ---------------- output side ----------------
  logic [0:0]        o_state_r;
  logic              push_s;
  logic              pop_s;
  logic [CHAR_W-1:0] head_s;
  logic [CW-1:0]     count_s;
  logic              empty_s;
  logic              full_s;

  // Full is judged on the registered count, so a same-cycle pop never admits a push.
  assign push_s           = (o_state_r == O_IDLE) && output_rdy_from_io && !full_s;
  assign output_ack_to_io = (o_state_r == O_ACK);

  // Unit-side acceptance FSM; flush deliberately does not touch it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_state_r <= O_IDLE;
    end else begin
      case (o_state_r)
        O_IDLE:  o_state_r <= push_s ? O_ACK : O_IDLE;
        O_ACK:   o_state_r <= output_rdy_from_io ? O_ACK : O_IDLE;
        default: o_state_r <= O_IDLE;
      endcase
    end
  end

  io_dev_fifo #(
    .DEPTH (DEPTH),
    .W     (CHAR_W)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push_s),
    .push_data (output_data_from_io),
    .pop       (pop_s),
    .flush     (flush_from_pnl),
    .head      (head_s),
    .count     (count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  logic [1:0] s_state_r;
  logic [1:0] s_state_nxt_s;
  logic [1:0] mask_r;
  logic [1:0] mask_nxt_s;
  logic [1:0] got_r;
  logic [1:0] got_nxt_s;
  logic       tmo_hit_s;

  // Sink fan-out FSM: wait for every enabled sink's ack, then for all acks to drop.
  always_comb begin
    s_state_nxt_s = s_state_r;
    mask_nxt_s    = mask_r;
    got_nxt_s     = got_r;
    pop_s         = 1'b0;
    case (s_state_r)
      S_IDLE: begin
        if (!empty_s) begin
          mask_nxt_s = snk_en_from_pnl;
          if (snk_en_from_pnl == 2'b00) pop_s = 1'b1;
          else                          s_state_nxt_s = S_RDY;
        end else begin
          s_state_nxt_s = S_IDLE;
        end
      end
      S_RDY: begin
        got_nxt_s = got_r | (snk_ack_from_dev & mask_r);
        if (got_nxt_s == mask_r) s_state_nxt_s = S_REL;
        else                     s_state_nxt_s = S_RDY;
      end
      S_REL: begin
        if ((snk_ack_from_dev & mask_r) == 2'b00) begin
          pop_s         = 1'b1;
          got_nxt_s     = 2'b00;
          s_state_nxt_s = S_IDLE;
        end else begin
          s_state_nxt_s = S_REL;
        end
      end
      default: begin
        s_state_nxt_s = S_IDLE;
        got_nxt_s     = 2'b00;
      end
    endcase
    if (tmo_hit_s) begin
      pop_s         = 1'b1;
      got_nxt_s     = 2'b00;
      s_state_nxt_s = S_IDLE;
    end else begin
      pop_s = pop_s;
    end
    if (flush_from_pnl) begin
      pop_s         = 1'b0;
      got_nxt_s     = 2'b00;
      s_state_nxt_s = S_IDLE;
    end else begin
      pop_s = pop_s;
    end
  end

  // Sink FSM state, latched sink mask and per-sink ack record.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s_state_r <= S_IDLE;
      mask_r    <= 2'b00;
      got_r     <= 2'b00;
    end else begin
      s_state_r <= s_state_nxt_s;
      mask_r    <= mask_nxt_s;
      got_r     <= got_nxt_s;
    end
  end

  // Sink-facing outputs derived from registered state; head is stable while not idle.
  always_comb begin
    snk_rdy_to_dev  = 2'b00;
    snk_data_to_dev = {CHAR_W{1'b0}};
    if (s_state_r != S_IDLE) begin
      snk_data_to_dev = head_s;
      snk_rdy_to_dev  = (s_state_r == S_RDY) ? (mask_r & ~got_r) : 2'b00;
    end else begin
      snk_data_to_dev = {CHAR_W{1'b0}};
      snk_rdy_to_dev  = 2'b00;
    end
  end

  assign output_busy_to_pnl = (count_s != CW'(0)) || (s_state_r != S_IDLE);

`ifdef IO_DEV_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_r;
  logic          timeout_r;

  assign tmo_hit_s = (s_state_r != S_IDLE) && (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));
  assign timeout_to_pnl = timeout_r;

  // Watchdog: counts cycles spent waiting on sinks, restarts whenever the FSM idles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tmo_cnt_r <= TW'(0);
    end else if ((s_state_r != S_IDLE) && (s_state_nxt_s != S_IDLE)) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_r <= TW'(0);
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timeout_r <= 1'b0;
    end else if (tmo_hit_s && !flush_from_pnl) begin
      timeout_r <= 1'b1;
    end else begin
      timeout_r <= timeout_r;
    end
  end
`else
  logic unused_tmo_s;
  assign unused_tmo_s   = (TIMEOUT_CYCLES > 0);
  assign tmo_hit_s      = 1'b0;
  assign timeout_to_pnl = 1'b0;
`endif

endmodule

// File: tb/tb_io_dev_scheduler.sv
// tb_io_dev_scheduler: directed tests for io_dev_scheduler with hand-computed expectations.
module tb_io_dev_scheduler;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       input_rdy_from_io = 1'b0;
  logic       input_val_to_io;
  logic [4:0] input_data_to_io;
  logic [1:0] src_rdy_to_dev;
  logic [1:0] src_val_from_dev = 2'b00;
  logic [4:0] src_data0_from_dev = 5'd0;
  logic [4:0] src_data1_from_dev = 5'd0;
  logic       input_src_sel_from_pnl = 1'b0;
  logic       output_rdy_from_io = 1'b0;
  logic [4:0] output_data_from_io = 5'd0;
  logic       output_ack_to_io;
  logic [1:0] snk_rdy_to_dev;
  logic [1:0] snk_ack_from_dev = 2'b00;
  logic [4:0] snk_data_to_dev;
  logic [1:0] snk_en_from_pnl = 2'b00;
  logic       flush_from_pnl = 1'b0;
  logic       output_busy_to_pnl;
  logic       timeout_to_pnl;

  int checks = 0;
  int errors = 0;

  io_dev_scheduler #(.DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .input_rdy_from_io(input_rdy_from_io), .input_val_to_io(input_val_to_io),
    .input_data_to_io(input_data_to_io), .src_rdy_to_dev(src_rdy_to_dev),
    .src_val_from_dev(src_val_from_dev), .src_data0_from_dev(src_data0_from_dev),
    .src_data1_from_dev(src_data1_from_dev), .input_src_sel_from_pnl(input_src_sel_from_pnl),
    .output_rdy_from_io(output_rdy_from_io), .output_data_from_io(output_data_from_io),
    .output_ack_to_io(output_ack_to_io), .snk_rdy_to_dev(snk_rdy_to_dev),
    .snk_ack_from_dev(snk_ack_from_dev), .snk_data_to_dev(snk_data_to_dev),
    .snk_en_from_pnl(snk_en_from_pnl), .flush_from_pnl(flush_from_pnl),
    .output_busy_to_pnl(output_busy_to_pnl), .timeout_to_pnl(timeout_to_pnl)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one character through the unit-side handshake; ok=0 if no ack within bound.
  task automatic push_char(input logic [4:0] d, output bit ok);
    ok = 1'b0;
    output_data_from_io = d;
    output_rdy_from_io  = 1'b1;
    for (int n = 0; n < 20; n++) begin
      step();
      if (output_ack_to_io) begin
        ok = 1'b1;
        break;
      end
    end
    output_rdy_from_io = 1'b0;
    step();
  endtask

  // Act as the printer for one character; ok=0 if rdy never arrives.
  task automatic sink_take(output logic [4:0] d, output bit ok);
    ok = 1'b0;
    d  = 5'd0;
    for (int n = 0; n < 20; n++) begin
      if (snk_rdy_to_dev[0]) break;
      step();
    end
    if (snk_rdy_to_dev[0]) begin
      ok = 1'b1;
      d  = snk_data_to_dev;
      snk_ack_from_dev = 2'b01;
      step();
      snk_ack_from_dev = 2'b00;
      step();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    checks++;
    if ({input_val_to_io, input_data_to_io, src_rdy_to_dev, output_ack_to_io,
         snk_rdy_to_dev, snk_data_to_dev, output_busy_to_pnl, timeout_to_pnl} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required all zero",
               {input_val_to_io, input_data_to_io, src_rdy_to_dev, output_ack_to_io,
                snk_rdy_to_dev, snk_data_to_dev, output_busy_to_pnl, timeout_to_pnl});
    end
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  task automatic test_input_tape();
    input_src_sel_from_pnl = 1'b0;
    input_rdy_from_io = 1'b1;
    step();
    checks++;
    if (src_rdy_to_dev !== 2'b01) begin errors++; $display("FAIL tape_rdy: got %b required 01", src_rdy_to_dev); end
    src_val_from_dev   = 2'b01;
    src_data0_from_dev = 5'b10011;
    src_data1_from_dev = 5'b01100;
    #1;
    checks++;
    if ({input_val_to_io, input_data_to_io} !== 6'b110011) begin
      errors++; $display("FAIL tape_fwd: got %b required 110011", {input_val_to_io, input_data_to_io});
    end
    step();
    checks++;
    if ({src_rdy_to_dev, input_val_to_io, input_data_to_io} !== 8'b00110011) begin
      errors++; $display("FAIL tape_hold: got %b required 00110011", {src_rdy_to_dev, input_val_to_io, input_data_to_io});
    end
    src_val_from_dev  = 2'b00;
    input_rdy_from_io = 1'b0;
    step();
    checks++;
    if ({src_rdy_to_dev, input_val_to_io, input_data_to_io} !== 8'd0) begin
      errors++; $display("FAIL tape_idle: got %b required 0", {src_rdy_to_dev, input_val_to_io, input_data_to_io});
    end
  endtask

  task automatic test_grant_lock();
    input_src_sel_from_pnl = 1'b0;
    input_rdy_from_io = 1'b1;
    step();
    src_val_from_dev   = 2'b01;
    src_data0_from_dev = 5'b00111;
    step();
    input_src_sel_from_pnl = 1'b1;
    src_val_from_dev   = 2'b11;
    src_data1_from_dev = 5'b11000;
    step();
    checks++;
    if ({src_rdy_to_dev, input_val_to_io, input_data_to_io} !== 8'b00100111) begin
      errors++; $display("FAIL grant_frozen: got %b required 00100111", {src_rdy_to_dev, input_val_to_io, input_data_to_io});
    end
    src_val_from_dev  = 2'b00;
    input_rdy_from_io = 1'b0;
    step();
    input_rdy_from_io = 1'b1;
    step();
    checks++;
    if (src_rdy_to_dev !== 2'b10) begin errors++; $display("FAIL kbd_rdy: got %b required 10", src_rdy_to_dev); end
    src_val_from_dev = 2'b10;
    #1;
    checks++;
    if ({input_val_to_io, input_data_to_io} !== 6'b111000) begin
      errors++; $display("FAIL kbd_fwd: got %b required 111000", {input_val_to_io, input_data_to_io});
    end
    step();
    src_val_from_dev  = 2'b00;
    input_rdy_from_io = 1'b0;
    step();
    checks++;
    if (input_val_to_io !== 1'b0) begin errors++; $display("FAIL kbd_idle: got %b required 0", input_val_to_io); end
  endtask

  task automatic test_fifo_full();
    logic [4:0] chars [5];
    logic [4:0] d;
    bit ok;
    chars[0] = 5'h11; chars[1] = 5'h02; chars[2] = 5'h1C; chars[3] = 5'h07; chars[4] = 5'h15;
    snk_en_from_pnl  = 2'b01;
    snk_ack_from_dev = 2'b00;
    for (int i = 0; i < 4; i++) begin
      push_char(chars[i], ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL fill_ack%0d: got no ack required ack", i); end
    end
    output_data_from_io = chars[4];
    output_rdy_from_io  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (output_ack_to_io !== 1'b0) begin errors++; $display("FAIL full_withheld: got %b required 0", output_ack_to_io); end
    end
    checks++;
    if ({snk_rdy_to_dev, snk_data_to_dev} !== {2'b01, chars[0]}) begin
      errors++; $display("FAIL full_head: got %b required %b", {snk_rdy_to_dev, snk_data_to_dev}, {2'b01, chars[0]});
    end
    snk_ack_from_dev = 2'b01;
    step();
    checks++;
    if (snk_rdy_to_dev !== 2'b00) begin errors++; $display("FAIL prn_rdy_drop: got %b required 00", snk_rdy_to_dev); end
    snk_ack_from_dev = 2'b00;
    step();
    checks++;
    if (output_ack_to_io !== 1'b0) begin errors++; $display("FAIL pop_same_cycle: got %b required 0", output_ack_to_io); end
    step();
    checks++;
    if (output_ack_to_io !== 1'b1) begin errors++; $display("FAIL fifth_ack: got %b required 1", output_ack_to_io); end
    output_rdy_from_io = 1'b0;
    step();
    for (int i = 1; i < 5; i++) begin
      sink_take(d, ok);
      checks++;
      if (!ok || d !== chars[i]) begin
        errors++; $display("FAIL fifo_order%0d: got %h ok=%0d required %h", i, d, ok, chars[i]);
      end
    end
  endtask

  task automatic test_fanout();
    bit ok;
    snk_en_from_pnl = 2'b11;
    push_char(5'b01010, ok);
    checks++;
    if ({snk_rdy_to_dev, snk_data_to_dev} !== 7'b1101010) begin
      errors++; $display("FAIL both_rdy: got %b required 1101010", {snk_rdy_to_dev, snk_data_to_dev});
    end
    snk_ack_from_dev = 2'b01;
    step();
    checks++;
    if (snk_rdy_to_dev !== 2'b10) begin errors++; $display("FAIL prn_only_drop: got %b required 10", snk_rdy_to_dev); end
    step();
    step();
    checks++;
    if (snk_rdy_to_dev !== 2'b10) begin errors++; $display("FAIL punch_wait: got %b required 10", snk_rdy_to_dev); end
    snk_ack_from_dev = 2'b11;
    step();
    checks++;
    if ({snk_rdy_to_dev, output_busy_to_pnl} !== 3'b001) begin
      errors++; $display("FAIL punch_drop: got %b required 001", {snk_rdy_to_dev, output_busy_to_pnl});
    end
    snk_ack_from_dev = 2'b10;
    step();
    checks++;
    if ({output_busy_to_pnl, snk_data_to_dev} !== 6'b101010) begin
      errors++; $display("FAIL no_pop_ack_high: got %b required 101010", {output_busy_to_pnl, snk_data_to_dev});
    end
    snk_ack_from_dev = 2'b00;
    step();
    checks++;
    if (output_busy_to_pnl !== 1'b0) begin errors++; $display("FAIL fanout_pop: got %b required 0", output_busy_to_pnl); end
    snk_en_from_pnl     = 2'b00;
    output_data_from_io = 5'h1F;
    output_rdy_from_io  = 1'b1;
    step();
    checks++;
    if ({output_ack_to_io, output_busy_to_pnl, snk_rdy_to_dev} !== 4'b1100) begin
      errors++; $display("FAIL discard_push: got %b required 1100", {output_ack_to_io, output_busy_to_pnl, snk_rdy_to_dev});
    end
    output_rdy_from_io = 1'b0;
    step();
    checks++;
    if ({output_ack_to_io, output_busy_to_pnl, snk_rdy_to_dev} !== 4'b0000) begin
      errors++; $display("FAIL discard_1cyc: got %b required 0000", {output_ack_to_io, output_busy_to_pnl, snk_rdy_to_dev});
    end
  endtask

  task automatic test_flush();
    logic [4:0] d;
    bit ok;
    snk_en_from_pnl = 2'b01;
    push_char(5'h01, ok);
    push_char(5'h02, ok);
    push_char(5'h03, ok);
    checks++;
    if (snk_rdy_to_dev !== 2'b01) begin errors++; $display("FAIL pre_flush_rdy: got %b required 01", snk_rdy_to_dev); end
    flush_from_pnl = 1'b1;
    step();
    flush_from_pnl = 1'b0;
    checks++;
    if ({snk_rdy_to_dev, output_busy_to_pnl} !== 3'b000) begin
      errors++; $display("FAIL flush_clear: got %b required 000", {snk_rdy_to_dev, output_busy_to_pnl});
    end
    output_data_from_io = 5'h0A;
    output_rdy_from_io  = 1'b1;
    flush_from_pnl      = 1'b1;
    step();
    flush_from_pnl = 1'b0;
    checks++;
    if ({output_ack_to_io, output_busy_to_pnl} !== 2'b10) begin
      errors++; $display("FAIL flush_beats_push: got %b required 10", {output_ack_to_io, output_busy_to_pnl});
    end
    output_rdy_from_io = 1'b0;
    step();
    push_char(5'h0C, ok);
    sink_take(d, ok);
    checks++;
    if (!ok || d !== 5'h0C) begin errors++; $display("FAIL post_flush_head: got %h ok=%0d required 0c", d, ok); end
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    snk_en_from_pnl  = 2'b01;
    snk_ack_from_dev = 2'b00;
    push_char(5'h03, ok);
    checks++;
    if (snk_rdy_to_dev !== 2'b01) begin errors++; $display("FAIL tmo_rdy: got %b required 01", snk_rdy_to_dev); end
`ifdef IO_DEV_TIMEOUT_EN
    n = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n++;
      if (timeout_to_pnl) break;
    end
    checks++;
    if (n != 16 || timeout_to_pnl !== 1'b1) begin
      errors++; $display("FAIL tmo_cycles: got %0d flag=%b required 16 flag=1", n, timeout_to_pnl);
    end
    checks++;
    if ({snk_rdy_to_dev, output_busy_to_pnl} !== 3'b000) begin
      errors++; $display("FAIL tmo_pop: got %b required 000", {snk_rdy_to_dev, output_busy_to_pnl});
    end
    repeat (5) step();
    checks++;
    if (timeout_to_pnl !== 1'b1) begin errors++; $display("FAIL tmo_sticky: got %b required 1", timeout_to_pnl); end
`else
    n = 40;
    repeat (n) step();
    checks++;
    if ({timeout_to_pnl, snk_rdy_to_dev} !== 3'b001) begin
      errors++; $display("FAIL no_tmo_wait: got %b required 001", {timeout_to_pnl, snk_rdy_to_dev});
    end
    flush_from_pnl = 1'b1;
    step();
    flush_from_pnl = 1'b0;
`endif
    resetn = 1'b0;
    #1;
    checks++;
    if (timeout_to_pnl !== 1'b0) begin errors++; $display("FAIL tmo_reset: got %b required 0", timeout_to_pnl); end
    @(negedge clk);
    resetn = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_input_tape();
    test_grant_lock();
    test_fifo_full();
    test_fanout();
    test_flush();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
